pwm_core: RTL and testbench

PWM_CORE -- requirements
Module: pwm_core

---
 rtl/pwm_core.sv | 129 ++++++++++++
 tb/tb_pwm_core.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_core.sv
// pwm_core: multi-channel PWM generator behind a small mmio register slot.
//
// Ports
//   clk      system clock, all state changes on its rising edge
//   reset    asynchronous, active-low reset
//   cs       slot select from the mmio controller
//   read     read strobe (unused: reads have no side effects)
//   write    write strobe, qualified by cs
//   addr     register index: 0 = DVSR, 1 = CTRL (bit0 en), 2+i = DUTY_i staging
//   wr_data  write data
//   rd_data  combinational read data for addr, zero-extended, 0 when unmapped
//   pwm_out  registered PWM outputs, one per channel
//
// A 32-bit prescaler q produces a tick whenever q >= DVSR. Each tick advances
// an R-bit phase counter d. A channel is high while d < its active duty. The
// active duties are reloaded from the staging registers only at the period
// boundary (or continuously while disabled), so staging writes never disturb
// a period that is already running.
module pwm_core #(
  parameter int W = 6,
  parameter int R = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic [W-1:0] pwm_out
);

  logic [31:0]  dvsr_reg;
  logic         en_reg;
  logic [31:0]  q_reg;
  logic [R-1:0] d_reg;
  logic [R:0]   stage_reg  [W];
  logic [R:0]   active_reg [W];

  logic wr_en;
  logic ctrl_clear;
  logic run;
  logic tick;
  logic load;
  logic unused;

  assign unused = read;

  assign wr_en = cs & write;

  // A CTRL write that clears en wins over a tick in the same cycle: the
  // counters return to 0 and the outputs drop on that very edge.
  assign ctrl_clear = wr_en && (addr == 5'd1) && !wr_data[0];
  assign run        = en_reg && !ctrl_clear;
  assign tick       = run && (q_reg >= dvsr_reg);

  // Active duties follow staging while stopped, and otherwise only on the
  // tick that ends the period (d at its all-ones value).
  assign load = !run || (tick && (&d_reg));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvsr_reg <= '0;
      en_reg   <= 1'b0;
    end else if (wr_en) begin
      if (addr == 5'd0) dvsr_reg <= wr_data;
      if (addr == 5'd1) en_reg   <= wr_data[0];
    end
  end

  // Comparing q >= DVSR (rather than equality) lets a DVSR lowered below the
  // current q take effect on the next edge instead of waiting for a wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
      d_reg <= '0;
    end else if (!run) begin
      q_reg <= '0;
      d_reg <= '0;
    end else if (tick) begin
      q_reg <= '0;
      d_reg <= d_reg + 1'b1;
    end else begin
      q_reg <= q_reg + 32'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_chan
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_reg[gi] <= '0;
        end else if (wr_en && (addr == 5'(gi + 2))) begin
          stage_reg[gi] <= wr_data[R:0];
        end
      end

      // Loads the pre-edge staging value, so a staging write coinciding with
      // the boundary only applies from the following period.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          active_reg[gi] <= '0;
        end else if (load) begin
          active_reg[gi] <= stage_reg[gi];
        end
      end

      // R+1-bit unsigned compare: duty 0 never high, duty >= 2^R always high.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pwm_out[gi] <= 1'b0;
        end else begin
          pwm_out[gi] <= run && ({1'b0, d_reg} < active_reg[gi]);
        end
      end
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if (addr == 5'd0) rd_data = dvsr_reg;
    if (addr == 5'd1) rd_data = {31'd0, en_reg};
    for (int i = 0; i < W; i++) begin
      if (addr == 5'(i + 2)) rd_data = 32'(stage_reg[i]);
    end
  end

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: self-checking bench for pwm_core with W=2, R=4.
// A behavioural model (period of 16 phases, plain integer arithmetic) is
// stepped on every clock edge and compared against pwm_out and rd_data,
// followed by directed scenarios and a randomized register-traffic phase.
module tb_pwm_core;
  localparam int W = 2;
  localparam int R = 4;
  localparam int PER = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cs = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [4:0]   addr = '0;
  logic [31:0]  wr_data = '0;
  logic [31:0]  rd_data;
  logic [W-1:0] pwm_out;

  pwm_core #(.W(W), .R(R)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  int unsigned m_dvsr, m_q;
  int          m_d;
  bit          m_en;
  int          m_stage [W];
  int          m_active[W];
  bit [W-1:0]  m_pwm;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_dvsr = 0; m_q = 0; m_d = 0; m_en = 0; m_pwm = '0;
    for (int i = 0; i < W; i++) begin m_stage[i] = 0; m_active[i] = 0; end
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return m_dvsr;
    if (a == 1) return {31'd0, m_en};
    if (a >= 2 && a < 2 + W) return 32'(m_stage[a-2]);
    return 32'd0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs seen at the edge.
  function automatic void m_step();
    bit wr, clr, running;
    bit [W-1:0] np;
    wr      = cs && write;
    clr     = wr && (addr == 5'd1) && !wr_data[0];
    running = m_en && !clr;
    np = '0;
    if (running) begin
      for (int i = 0; i < W; i++) np[i] = (m_d < m_active[i]);
      if (m_q >= m_dvsr) begin
        if (m_d == PER - 1)
          for (int i = 0; i < W; i++) m_active[i] = m_stage[i];
        m_d = (m_d + 1) % PER;
        m_q = 0;
      end else begin
        m_q = m_q + 1;
      end
    end else begin
      m_q = 0; m_d = 0;
      for (int i = 0; i < W; i++) m_active[i] = m_stage[i];
    end
    m_pwm = np;
    if (wr) begin
      if (addr == 5'd0) m_dvsr = wr_data;
      else if (addr == 5'd1) m_en = wr_data[0];
      else if (addr >= 5'd2 && addr < 5'(2 + W)) m_stage[addr-2] = int'(wr_data[R:0]);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    check_val("pwm", 32'(pwm_out), 32'(m_pwm));
  endtask

  task automatic wr(input int a, input logic [31:0] dat);
    cs = 1'b1; write = 1'b1; addr = 5'(a); wr_data = dat;
    cyc();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input int a);
    addr = 5'(a);
    #1;
    check_val("rd", rd_data, m_read(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int cnt, cnt1, k, guard;
  int atab[6] = '{0, 1, 2, 3, 4, 31};

  initial begin
    m_reset();
    // S1: reset state
    #12;
    check_val("s1_pwm", 32'(pwm_out), 32'd0);
    rd(0); rd(1); rd(2); rd(3); rd(31);
    reset = 1'b1;

    // S2: basic waveform, duty 4 of 16, DVSR=0
    wr(1, 0); wr(0, 0); wr(2, 4); wr(3, 0); wr(1, 1);
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      for (int j = 0; j < PER; j++) begin
        cyc();
        check_val("s2_wave", 32'(pwm_out[0]), 32'(j < 4));
        cnt += pwm_out[0];
      end
      check_val("s2_hi", cnt, 4);
    end

    // S4: double buffering, DUTY_0 rewritten at d=2
    wr(1, 0); wr(0, 0); wr(2, 4); wr(1, 1);
    cnt = 0;
    cyc(); cnt += pwm_out[0];
    cyc(); cnt += pwm_out[0];
    wr(2, 12); cnt += pwm_out[0];
    rd(2);
    check_val("s4_rb", rd_data, 32'd12);
    for (int j = 0; j < 13; j++) begin cyc(); cnt += pwm_out[0]; end
    check_val("s4_cur", cnt, 4);
    cnt = 0;
    for (int j = 0; j < PER; j++) begin cyc(); cnt += pwm_out[0]; end
    check_val("s4_next", cnt, 12);

    // S3: extreme duties across 3 periods with DVSR=1
    wr(1, 0); wr(0, 1); wr(2, 16); wr(3, 0); wr(1, 1);
    cnt = 0; cnt1 = 0;
    for (int j = 0; j < 96; j++) begin
      cyc(); cnt += pwm_out[0]; cnt1 += pwm_out[1];
    end
    check_val("s3_hi0", cnt, 96);
    check_val("s3_lo1", cnt1, 0);

    // S5: lower DVSR below q, then clear en mid-period
    wr(1, 0); wr(0, 100); wr(2, 1); wr(1, 1);
    guard = 0;
    while (m_q != 50 && guard < 200) begin cyc(); guard++; end
    if (guard >= 200) check_val("s5_wait", 32'd1, 32'd0);
    wr(0, 3);
    cyc();
    check_val("s5_tick", 32'(pwm_out[0]), 32'd1);
    cyc();
    check_val("s5_after", 32'(pwm_out[0]), 32'd0);
    for (int j = 0; j < 40; j++) cyc();
    wr(2, 8);
    for (int j = 0; j < 90; j++) cyc();
    wr(1, 0);
    check_val("s5_off", 32'(pwm_out), 32'd0);
    cyc();
    check_val("s5_off2", 32'(pwm_out), 32'd0);
    wr(1, 1);
    cyc();
    check_val("s5_restart", 32'(pwm_out[0]), 32'd1);

    // S6: asynchronous reset between edges while output high
    wr(1, 0); wr(0, 0); wr(2, 8); wr(1, 1);
    cyc();
    check_val("s6_pre", 32'(pwm_out[0]), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_val("s6_async", 32'(pwm_out), 32'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    rd(0); rd(1); rd(2); rd(3);
    cyc(); cyc();
    check_val("s6_idle", 32'(pwm_out), 32'd0);

    // randomized register traffic against the model
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      if (k < 3) begin
        int a;
        logic [31:0] dat;
        a = atab[$urandom_range(0, 5)];
        dat = $urandom;
        if (a == 0) dat = $urandom_range(0, 3);
        if (a == 1) dat = {dat[31:1], 1'($urandom_range(0, 4) != 0)};
        wr(a, dat);
      end else if (k == 3) begin
        cs = 1'b1; read = 1'b1;
        cyc();
        cs = 1'b0; read = 1'b0;
      end else begin
        cyc();
      end
      rd(atab[$urandom_range(0, 5)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
